// File: rtl/clk_duty_meter.sv
// ---------------------------------------------------------------------------
// clk_duty_meter
//
// Measures the period and high time of a free-running clock or PWM signal
// (sig_in) that is asynchronous to clk. Both are reported as whole counts of
// clk cycles. One result is produced on each rising edge of the synchronised
// signal after the meter has been armed by a first rising edge.
//
// Parameters
//   CNT_W        width of the period/high counters and outputs (>= 4)
//   SYNC_STAGES  flops in the sig_in synchronizer (>= 2)
//
// Ports
//   clk        in   system clock, rising-edge logic
//   rst_n      in   asynchronous active-low reset
//   sig_in     in   measured signal, asynchronous to clk
//   enable     in   level-sensitive measurement enable
//   period_o   out  last measured period in clk cycles
//   high_o     out  last measured high time in clk cycles
//   valid_o    out  one-cycle pulse when period_o/high_o update
//   timeout_o  out  sticky: no rising edge within 2^CNT_W-1 cycles
//   busy_o     out  high while arming or measuring
// ---------------------------------------------------------------------------
module clk_duty_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Last count a period may hold without a rise: one more cycle would
    // reach 2^CNT_W-1, which is the timeout threshold.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d_q;
    logic [CNT_W-1:0]       per_cnt_q;
    logic [CNT_W-1:0]       hi_cnt_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic                   valid_q;
    logic                   timeout_q;
    logic                   busy_q;

    logic sig_s;
    logic rise;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d_q;

    // Synchronizer plus one delay flop for edge detection. sig_in is only
    // ever touched by the first flop of this chain.
    // NOTE: async reset covers every flop here, including the synchronizer,
    // so a reset mid-measurement cannot leave a stale edge in the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            sig_d_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of
            // its neighbour; blocking would collapse the chain to one flop.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d_q <= sig_s;
        end
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            per_cnt_q <= CNT_ZERO;
            hi_cnt_q  <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable) begin
                // Dropping enable wins over everything, including a
                // coincident rise; the partial count is thrown away.
                state_q   <= S_IDLE;
                per_cnt_q <= CNT_ZERO;
                hi_cnt_q  <= CNT_ZERO;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q   <= S_ARM;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                    S_ARM: begin
                        if (rise) begin
                            state_q   <= S_MEASURE;
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                        end
                    end
                    S_MEASURE: begin
                        if (rise) begin
                            // Rise beats the timeout when both land together.
                            period_q  <= per_cnt_q;
                            high_q    <= hi_cnt_q;
                            valid_q   <= 1'b1;
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                        end else if (per_cnt_q == CNT_LAST) begin
                            // Period would reach 2^CNT_W-1: give up and re-arm,
                            // so the next result needs two fresh rises.
                            state_q   <= S_ARM;
                            timeout_q <= 1'b1;
                            per_cnt_q <= CNT_ZERO;
                            hi_cnt_q  <= CNT_ZERO;
                        end else begin
                            per_cnt_q <= per_cnt_q + CNT_ONE;
                            if (sig_s) begin
                                hi_cnt_q <= hi_cnt_q + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_clk_duty_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_duty_meter
//
// Scoreboard bench for clk_duty_meter (CNT_W=8 so the timeout is reachable
// quickly). sig_in is driven 2 ns after a clk rising edge, in whole clk
// cycles. Each time the bench drives a rising edge that the meter will turn
// into a result, it pushes the expected period, high time and the clk cycle
// on which valid_o must be seen; a monitor pops and compares on every valid_o.
// ---------------------------------------------------------------------------
module tb_clk_duty_meter;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    // Longest period that still yields a result (2^CNT_W - 2).
    localparam int PMAX  = (1 << CNT_W) - 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             timeout_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   last_valid = 1'b0;

    // Bench-side model of what the meter has seen.
    bit armed     = 1'b0;
    bit have_prev = 1'b0;
    int prev_h    = 0;
    int prev_l    = 0;

    clk_duty_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .enable    (enable),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid_o must match the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (valid_o === 1'b1) begin
            checks++;
            if (last_valid) begin
                failures++;
                $display("FAIL valid_spacing: valid_o high on consecutive cycles at cycle %0d", cyc);
            end
            if (high_o > period_o) begin
                failures++;
                $display("FAIL high_le_period: high_o=%0d exceeds period_o=%0d", high_o, period_o);
            end
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: cycle %0d period_o=%0d high_o=%0d, none expected",
                         cyc, period_o, high_o);
            end else begin
                mon_e = sb.pop_front();
                if (period_o !== mon_e.period || high_o !== mon_e.high || cyc !== mon_e.cyc) begin
                    failures++;
                    $display("FAIL result: got period=%0d high=%0d cycle=%0d, expected period=%0d high=%0d cycle=%0d",
                             period_o, high_o, cyc, mon_e.period, mon_e.high, mon_e.cyc);
                end
            end
        end
        last_valid = (valid_o === 1'b1);
    end

    // Move to 2 ns after the next clk rising edge.
    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // One sig_in period: h cycles high, l cycles low. Called at an aligned time.
    task automatic drive_period(input int h, input int l);
        if (armed && have_prev) begin
            sb.push_back('{CNT_W'(prev_h + prev_l), CNT_W'(prev_h), cyc + 1 + SYNC});
        end
        sig_in = 1'b1;
        repeat (h) @(posedge clk);
        #2;
        sig_in = 1'b0;
        repeat (l) @(posedge clk);
        #2;
        have_prev = armed && (h + l <= PMAX);
        prev_h    = h;
        prev_l    = l;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: %0d expected results still pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks += 5;
        if (period_o !== '0)    begin failures++; $display("FAIL reset_period: got %0d want 0", period_o); end
        if (high_o !== '0)      begin failures++; $display("FAIL reset_high: got %0d want 0", high_o); end
        if (valid_o !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        if (busy_o !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        align();
        rst_n = 1'b1;
        align();
        align();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_duty25();
        enable = 1'b1;
        align();
        align();
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL arm_busy: got %b want 1", busy_o); end
        armed     = 1'b1;
        have_prev = 1'b0;
        repeat (6) drive_period(1, 3);
        check_drained("duty25");
    endtask

    task automatic test_duty50();
        repeat (5) drive_period(4, 4);
        check_drained("duty50");
    endtask

    task automatic test_timeout();
        int c;
        enable = 1'b0;
        repeat (3) align();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL disabled_busy: got %b want 0", busy_o); end
        enable = 1'b1;
        align();
        align();
        have_prev = 1'b0;
        c = cyc;
        drive_period(1, 0);
        have_prev = 1'b0;
        while (cyc < c + 256) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b want 0 at cycle %0d", timeout_o, cyc); end
        @(posedge clk);
        #1;
        checks += 4;
        if (timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_set: got %b want 1 at cycle %0d", timeout_o, cyc); end
        if (busy_o !== 1'b1)    begin failures++; $display("FAIL timeout_busy: got %b want 1", busy_o); end
        if (period_o !== 8'd8)  begin failures++; $display("FAIL timeout_period_kept: got %0d want 8", period_o); end
        if (high_o !== 8'd4)    begin failures++; $display("FAIL timeout_high_kept: got %0d want 4", high_o); end
        #1;
        repeat (4) drive_period(3, 1);
        check_drained("timeout");
        checks++;
        if (timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b want 1", timeout_o); end
    endtask

    task automatic test_enable_gap();
        repeat (2) drive_period(2, 2);
        enable = 1'b0;
        armed  = 1'b0;
        repeat (3) drive_period(2, 2);
        checks += 4;
        if (busy_o !== 1'b0)    begin failures++; $display("FAIL gap_busy: got %b want 0", busy_o); end
        if (timeout_o !== 1'b1) begin failures++; $display("FAIL gap_timeout_kept: got %b want 1", timeout_o); end
        if (period_o !== 8'd4)  begin failures++; $display("FAIL gap_period_kept: got %0d want 4", period_o); end
        if (high_o !== 8'd2)    begin failures++; $display("FAIL gap_high_kept: got %0d want 2", high_o); end
        enable = 1'b1;
        align();
        align();
        armed     = 1'b1;
        have_prev = 1'b0;
        checks += 2;
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL reenable_timeout: got %b want 0", timeout_o); end
        if (busy_o !== 1'b1)    begin failures++; $display("FAIL reenable_busy: got %b want 1", busy_o); end
        repeat (3) drive_period(2, 3);
        check_drained("enable_gap");
    endtask

    task automatic test_reset_mid();
        repeat (2) drive_period(3, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (period_o !== '0)    begin failures++; $display("FAIL midrst_period: got %0d want 0", period_o); end
        if (high_o !== '0)      begin failures++; $display("FAIL midrst_high: got %0d want 0", high_o); end
        if (valid_o !== 1'b0)   begin failures++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL midrst_timeout: got %b want 0", timeout_o); end
        if (busy_o !== 1'b0)    begin failures++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        #2;
        rst_n = 1'b1;
        align();
        align();
        have_prev = 1'b0;
        repeat (3) drive_period(3, 2);
        check_drained("reset_mid");
    endtask

    task automatic test_threshold();
        drive_period(1, PMAX - 1);
        drive_period(2, 2);
        checks++;
        if (timeout_o !== 1'b0) begin failures++; $display("FAIL threshold_rise_wins: timeout_o=%b want 0", timeout_o); end
        drive_period(1, PMAX);
        drive_period(2, 2);
        checks++;
        if (timeout_o !== 1'b1) begin failures++; $display("FAIL threshold_over: timeout_o=%b want 1", timeout_o); end
        drive_period(2, 2);
        check_drained("threshold");
    endtask

    task automatic test_jitter();
        repeat (20) drive_period($urandom_range(4, 2), $urandom_range(4, 2));
        check_drained("jitter");
    endtask

    initial begin
        test_reset();
        test_duty25();
        test_duty50();
        test_timeout();
        test_enable_gap();
        test_reset_mid();
        test_threshold();
        test_jitter();
        repeat (10) align();
        check_drained("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
